poly_diff_reader: RTL and testbench

//  Host-side sequencer and decoder for the finite-difference polynomial engine.

---
 rtl/poly_diff_pkg.sv | 26 ++
 rtl/poly_diff_pulse.sv | 55 +++++
 rtl/poly_diff_reader.sv | 115 +++++++++++
 tb/tb_poly_diff_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/poly_diff_pkg.sv
// Shared constants for the finite-difference polynomial engine reader: FSM
// encoding, default widths and the engine's power-on difference table.
package poly_diff_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S_LO = 3'd1;
  localparam logic [2:0] S_HI = 3'd2;
  localparam logic [2:0] SAMP = 3'd3;
  localparam logic [2:0] N_LO = 3'd4;
  localparam logic [2:0] N_HI = 3'd5;
  localparam logic [2:0] FIN  = 3'd6;

  localparam int W_DEF     = 10;
  localparam int NSAMP_MIN = 4;

  // Engine setup table loaded on a start press.
  localparam int H0     = 1;
  localparam int F0     = 5;
  localparam int G0     = 10;
  localparam int G_STEP = 6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/poly_diff_pulse.sv
// Timed button press: holds btn low for PULSE_CYC cycles, then waits
// SETTLE_CYC cycles with btn high and flags rdy in the last settle cycle.
module poly_diff_pulse
  import poly_diff_pkg::*;
#(
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic btn,
  output logic rdy
);

  localparam int TW = $clog2(max_int(PULSE_CYC, SETTLE_CYC) + 1);

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_LO   = 2'd1;
  localparam logic [1:0] P_HI   = 2'd2;

  logic [1:0]    phase;
  logic [TW-1:0] tmr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= P_IDLE;
      tmr   <= '0;
      btn   <= 1'b1;
    end else begin
      case (phase)
        P_IDLE: if (trig) begin
          phase <= P_LO;
          btn   <= 1'b0;
          tmr   <= TW'(PULSE_CYC - 1);
        end
        P_LO: if (tmr == '0) begin
          phase <= P_HI;
          btn   <= 1'b1;
          tmr   <= TW'(SETTLE_CYC - 1);
        end else begin
          tmr <= tmr - 1'b1;
        end
        P_HI: if (tmr == '0) phase <= P_IDLE;
              else           tmr   <= tmr - 1'b1;
        default: phase <= P_IDLE;
      endcase
    end
  end

  assign rdy = (phase == P_HI) && (tmr == '0);

endmodule

// File: rtl/poly_diff_reader.sv
// Host sequencer for the difference engine: presses start/nextn, samples
// eng_data and backward-differences it into h0..d3. Define POLY_DIFF_CHECK_EN
// to build the constant-third-difference checker driving err.
module poly_diff_reader
  import poly_diff_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int NSAMP      = 6,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] eng_data,
  output logic         eng_start,
  output logic         eng_nextn,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] h0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic         err
);

  localparam logic [4:0] K_LAST = 5'(NSAMP - 1);

  logic [2:0]   state;
  logic [4:0]   k;
  logic [W-1:0] s, a1, a2;
  logic [W-1:0] e1, e2, e3;
  logic         start_trig, next_trig;
  logic         start_rdy, next_rdy;

  assign start_trig = (state == IDLE) && go;
  assign next_trig  = (state == SAMP) && (k != K_LAST);
  assign busy       = (state != IDLE);

  poly_diff_pulse #(.PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)) u_start (
    .clk(clk), .rst(rst), .trig(start_trig), .btn(eng_start), .rdy(start_rdy)
  );

  poly_diff_pulse #(.PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)) u_next (
    .clk(clk), .rst(rst), .trig(next_trig), .btn(eng_nextn), .rdy(next_rdy)
  );

  // Differences wrap mod 2^W by construction; wrap is not an error.
  always_comb begin
    e1 = eng_data - s;
    e2 = e1 - a1;
    e3 = e2 - a2;
  end

  // NOTE: the differencing history is reset along with the FSM so outputs
  // read zero after reset rather than whatever the last run left behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
      done  <= 1'b0;
      s     <= '0;
      a1    <= '0;
      a2    <= '0;
      h0    <= '0;
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state <= S_LO;
          done  <= 1'b0;
          k     <= '0;
        end
        // The button rises at the end of its low phase; the pulse block's
        // rdy then marks the last settle cycle before sampling.
        S_LO: if (eng_start) state <= S_HI;
        S_HI: if (start_rdy) state <= SAMP;
        SAMP: begin
          case (k)
            5'd0:    h0 <= eng_data;
            5'd1:    d1 <= e1;
            5'd2:    d2 <= e2;
            5'd3:    d3 <= e3;
            default: ;
          endcase
          s     <= eng_data;
          a1    <= e1;
          a2    <= e2;
          k     <= k + 5'd1;
          state <= (k == K_LAST) ? FIN : N_LO;
        end
        N_LO: if (eng_nextn) state <= N_HI;
        N_HI: if (next_rdy)  state <= SAMP;
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POLY_DIFF_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   err <= 1'b0;
    else if (start_trig)                        err <= 1'b0;
    else if (state == SAMP && k >= 5'd4 && e3 != d3) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_diff_reader.sv
// Bench for poly_diff_reader: a difference-engine model (or a sample stub)
// on eng_*, expected tables queued at go and compared when done rises.
module tb_poly_diff_reader;
  import poly_diff_pkg::*;

  localparam int W = W_DEF;

  typedef struct {
    logic [W-1:0] h0, d1, d2, d3;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go  = 1'b0;
  logic [W-1:0] eng_data;
  logic         eng_start, eng_nextn, busy, done, err;
  logic [W-1:0] h0, d1, d2, d3;

  // Engine model / stub state, owned by the negedge process below.
  logic [W-1:0] h_m, f_m, g_m;
  logic [2:0]   sidx;
  logic         prev_start, prev_nextn;
  int           start_cnt, nextn_cnt;

  // Bench controls, owned by the initial block.
  logic         use_stub    = 1'b0;
  logic         eng_rst_req = 1'b1;
  logic         cnt_clr     = 1'b0;
  logic [W-1:0] stub_mem [0:7];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  poly_diff_reader dut (
    .clk(clk), .rst(rst), .go(go), .eng_data(eng_data),
    .eng_start(eng_start), .eng_nextn(eng_nextn), .busy(busy), .done(done),
    .h0(h0), .d1(d1), .d2(d2), .d3(d3), .err(err)
  );

  assign eng_data = use_stub ? stub_mem[sidx] : h_m;

  // Engine acts on button release; value is stable long before sampling.
  always @(negedge clk) begin
    if (eng_rst_req) begin
      h_m <= W'(H0); f_m <= W'(F0); g_m <= W'(G0);
      sidx <= '0; prev_start <= 1'b1; prev_nextn <= 1'b1;
    end else begin
      if (!prev_start && eng_start) begin
        h_m <= W'(H0); f_m <= W'(F0); g_m <= W'(G0); sidx <= '0;
      end else if (!prev_nextn && eng_nextn) begin
        h_m <= h_m + f_m; f_m <= f_m + g_m; g_m <= g_m + W'(G_STEP);
        sidx <= sidx + 3'd1;
      end
      prev_start <= eng_start;
      prev_nextn <= eng_nextn;
    end
    if (cnt_clr) begin
      start_cnt <= 0; nextn_cnt <= 0;
    end else begin
      if (prev_start && !eng_start) start_cnt <= start_cnt + 1;
      if (prev_nextn && !eng_nextn) nextn_cnt <= nextn_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
  endtask

  task automatic start_go();
    @(negedge clk) go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic load_stub(input int v0, input int v1, input int v2,
                           input int v3, input int v4, input int v5);
    stub_mem[0] = W'(v0); stub_mem[1] = W'(v1); stub_mem[2] = W'(v2);
    stub_mem[3] = W'(v3); stub_mem[4] = W'(v4); stub_mem[5] = W'(v5);
    stub_mem[6] = '0;     stub_mem[7] = '0;
  endtask

  // One run; g1/g2 are cycle offsets (after go) at which go is re-pulsed.
  task automatic run_and_check(input string tag, input int g1, input int g2);
    exp_t e;
    int   lat = 0;
    start_go();
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      go = (lat == g1) || (lat == g2);
      if (done) break;
    end
    go = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'd37);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_h0"}, 32'(h0), 32'(e.h0));
      check({tag, "_d1"}, 32'(d1), 32'(e.d1));
      check({tag, "_d2"}, 32'(d2), 32'(e.d2));
      check({tag, "_d3"}, 32'(d3), 32'(e.d3));
      check({tag, "_err"}, 32'(err), 32'(e.err));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, 32'(eng_start), 32'd1);
    check({tag, "_nextn"}, 32'(eng_nextn), 32'd1);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_h0"},    32'(h0), 32'd0);
    check({tag, "_d1"},    32'(d1), 32'd0);
    check({tag, "_d2"},    32'(d2), 32'd0);
    check({tag, "_d3"},    32'(d3), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    logic exp_chk_err;
    int   wait_cyc;
`ifdef POLY_DIFF_CHECK_EN
    exp_chk_err = 1'b1;
`else
    exp_chk_err = 1'b0;
`endif
    load_stub(0, 0, 0, 0, 0, 0);
    cnt_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk) begin rst = 1'b1; eng_rst_req = 1'b0; cnt_clr = 1'b0; end
    repeat (2) @(posedge clk);

    // Scenario 1: engine model, samples 1,6,21,52,105,186.
    sb.push_back('{h0: W'(1), d1: W'(5), d2: W'(10), d3: W'(6), err: 1'b0});
    run_and_check("model", -1, -1);

    // Scenario 2/6: stub with a bad fifth sample; err only with the checker.
    load_stub(1, 6, 21, 52, 100, 100);
    use_stub = 1'b1;
    sb.push_back('{h0: W'(1), d1: W'(5), d2: W'(10), d3: W'(6), err: exp_chk_err});
    run_and_check("stub_bad", -1, -1);

    // Scenario 3: first difference wraps (3 - 1020 = 7 mod 1024).
    load_stub(1020, 3, 30, 81, 160, 271);
    sb.push_back('{h0: W'(1020), d1: W'(7), d2: W'(20), d3: W'(4), err: 1'b0});
    run_and_check("wrap", -1, -1);

    // Scenario 4: go re-pulsed mid-run and during FIN is dropped.
    use_stub = 1'b0;
    clr_counts();
    sb.push_back('{h0: W'(1), d1: W'(5), d2: W'(10), d3: W'(6), err: 1'b0});
    run_and_check("go_busy", 10, 36);
    repeat (5) @(posedge clk);
    #1;
    check("go_busy_idle", 32'(busy), 32'd0);
    check("go_busy_done_level", 32'(done), 32'd1);
    check("go_busy_start_pulses", 32'(start_cnt), 32'd1);
    check("go_busy_nextn_pulses", 32'(nextn_cnt), 32'd5);

    // Scenario 5: async reset during the third nextn press.
    clr_counts();
    start_go();
    wait_cyc = 0;
    while (wait_cyc < 200 && !(nextn_cnt == 3 && !eng_nextn)) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("rst_mid_reached", 32'(nextn_cnt == 3 && !eng_nextn), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (3) @(posedge clk);
    @(negedge clk) begin rst = 1'b1; eng_rst_req = 1'b1; end
    @(negedge clk) eng_rst_req = 1'b0;
    sb.push_back('{h0: W'(1), d1: W'(5), d2: W'(10), d3: W'(6), err: 1'b0});
    run_and_check("after_rst", -1, -1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
